// File: rtl/data_memory_waitstate_if.sv
// Request/response bundle for data_memory_waitstate.
// master drives req_*, slave drives req_ready and resp_*.
interface data_memory_waitstate_if #(
  parameter int DATA_WIDTH = 24,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_write_data;
  logic [LANES-1:0]      req_lane_enable;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_read_data;
  logic                  resp_error;

  modport master (
    output req_valid,
    output req_write,
    output req_address,
    output req_write_data,
    output req_lane_enable,
    input  req_ready,
    input  resp_valid,
    input  resp_read_data,
    input  resp_error
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_address,
    input  req_write_data,
    input  req_lane_enable,
    output req_ready,
    output resp_valid,
    output resp_read_data,
    output resp_error
  );
endinterface

// File: rtl/data_memory_waitstate.sv
// Word-addressed data memory with valid/ready request, lane writes,
// fixed wait states and range check. Ports: clk, reset_n, bus (slave).
module data_memory_waitstate #(
  parameter int DATA_WIDTH  = 24,
  parameter int LANE_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 14,
  parameter int DEPTH       = 16384,
  parameter int WAIT_STATES = 2
) (
  input logic clk,
  input logic reset_n,
  data_memory_waitstate_if.slave bus
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [LANES-1:0]      r_lane;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_err;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_access;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_cur;
  logic [DATA_WIDTH-1:0] w_merged;

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_read_data = r_resp_data;
  assign bus.resp_error     = r_resp_err;

  assign w_accept   = bus.req_valid && bus.req_ready;
  // Extra bit keeps the compare valid when DEPTH == 2**ADDR_WIDTH.
  assign w_in_range = ({1'b0, r_addr} < LIMIT);
  assign w_idx      = r_addr[IDX_W-1:0];
  assign w_cur      = r_mem[w_idx];

  always_comb begin
    w_next   = r_state;
    w_access = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next   = S_IDLE;
          w_access = 1'b1;
        end
      end
    endcase
  end

  // Reads fall through unchanged since no lane is replaced.
  always_comb begin
    w_merged = w_cur;
    for (int i = 0; i < LANES; i++) begin
      if (r_write && r_lane[i])
        w_merged[i*LANE_WIDTH +: LANE_WIDTH] =
          r_wdata[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_lane  <= '0;
    end else if (w_accept) begin
      r_cnt   <= WS;
      r_write <= bus.req_write;
      r_addr  <= bus.req_address;
      r_wdata <= bus.req_write_data;
      r_lane  <= bus.req_lane_enable;
    end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_access;
      if (w_access) begin
        r_resp_data <= w_in_range ? w_merged : '0;
        r_resp_err  <= !w_in_range;
      end
    end
  end

  // Array has no reset; reset forces IDLE so an in-flight write is dropped.
  always_ff @(posedge clk) begin
    if (w_access && w_in_range && r_write)
      r_mem[w_idx] <= w_merged;
  end
endmodule

// File: tb/tb_data_memory_waitstate.sv
// Directed bench for data_memory_waitstate.
// Instance A: 2 wait states, DEPTH 1000. Instance B: 0 wait states.
module tb_data_memory_waitstate;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  data_memory_waitstate_if #(.DATA_WIDTH(24), .LANE_WIDTH(8),
    .ADDR_WIDTH(14)) ifA ();
  data_memory_waitstate_if #(.DATA_WIDTH(24), .LANE_WIDTH(8),
    .ADDR_WIDTH(14)) ifB ();

  data_memory_waitstate #(
    .DATA_WIDTH(24), .LANE_WIDTH(8), .ADDR_WIDTH(14),
    .DEPTH(1000), .WAIT_STATES(2)
  ) dutA (.clk(clk), .reset_n(reset_n), .bus(ifA.slave));

  data_memory_waitstate #(
    .DATA_WIDTH(24), .LANE_WIDTH(8), .ADDR_WIDTH(14),
    .DEPTH(16), .WAIT_STATES(0)
  ) dutB (.clk(clk), .reset_n(reset_n), .bus(ifB.slave));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic a_access(input logic w, input logic [13:0] a,
                          input logic [23:0] d, input logic [2:0] ln,
                          output logic [23:0] rd, output logic er,
                          output int edges, output int rlow);
    bit seen;
    seen = 0; rd = '0; er = 1'b0; edges = -1; rlow = 0;
    @(negedge clk);
    ifA.req_valid       = 1'b1;
    ifA.req_write       = w;
    ifA.req_address     = a;
    ifA.req_write_data  = d;
    ifA.req_lane_enable = ln;
    @(posedge clk);
    #1;
    ifA.req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ifA.resp_valid) begin
        seen  = 1;
        edges = k - 1;
        rd    = ifA.resp_read_data;
        er    = ifA.resp_error;
        break;
      end
      if (!ifA.req_ready) rlow++;
    end
    if (!seen) chk("a_timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      chk("a_pulse_w", {31'd0, ifA.resp_valid}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [23:0] rd;
  logic        er;
  int          edges, rlow;
  logic [23:0] bexp [4];
  int          acc_cyc [4];
  int          nacc, nresp, cyc, pulse_bad;
  bit          prev_v;

  initial begin
    ifA.req_valid = 1'b0; ifA.req_write = 1'b0; ifA.req_address = '0;
    ifA.req_write_data = '0; ifA.req_lane_enable = '0;
    ifB.req_valid = 1'b0; ifB.req_write = 1'b0; ifB.req_address = '0;
    ifB.req_write_data = '0; ifB.req_lane_enable = '0;
    bexp[0] = 24'h0A0001; bexp[1] = 24'h0B0102;
    bexp[2] = 24'h0C0203; bexp[3] = 24'h0D0304;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ifA.req_ready}, 32'd1);
    chk("rst_valid", {31'd0, ifA.resp_valid}, 32'd0);
    chk("rst_data",  {8'd0, ifA.resp_read_data}, 32'd0);
    chk("rst_err",   {31'd0, ifA.resp_error}, 32'd0);
    reset_n = 1'b1;

    // full-word write then read
    a_access(1'b1, 14'd0, 24'hFFFF10, 3'b111, rd, er, edges, rlow);
    chk("wr0_data", {8'd0, rd}, 32'hFFFF10);
    chk("wr0_err", {31'd0, er}, 32'd0);
    chk("wr0_lat", edges, 32'd3);
    chk("wr0_rdy_low", rlow, 32'd3);
    a_access(1'b0, 14'd0, 24'h0, 3'b000, rd, er, edges, rlow);
    chk("rd0_data", {8'd0, rd}, 32'hFFFF10);
    chk("rd0_err", {31'd0, er}, 32'd0);
    chk("rd0_lat", edges, 32'd3);
    chk("rd0_rdy_low", rlow, 32'd3);

    // lane write
    a_access(1'b1, 14'd5, 24'h123456, 3'b111, rd, er, edges, rlow);
    chk("wr5_full", {8'd0, rd}, 32'h123456);
    a_access(1'b1, 14'd5, 24'hABCDEF, 3'b010, rd, er, edges, rlow);
    chk("wr5_lane", {8'd0, rd}, 32'h12CD56);
    a_access(1'b0, 14'd5, 24'h0, 3'b000, rd, er, edges, rlow);
    chk("rd5_lane", {8'd0, rd}, 32'h12CD56);
    a_access(1'b1, 14'd5, 24'hFFFFFF, 3'b000, rd, er, edges, rlow);
    chk("wr5_nolane", {8'd0, rd}, 32'h12CD56);
    chk("wr5_nolane_err", {31'd0, er}, 32'd0);
    a_access(1'b0, 14'd5, 24'h0, 3'b000, rd, er, edges, rlow);
    chk("rd5_nolane", {8'd0, rd}, 32'h12CD56);

    // out of range
    a_access(1'b1, 14'd999, 24'h0A0B0C, 3'b111, rd, er, edges, rlow);
    chk("wr999", {8'd0, rd}, 32'h0A0B0C);
    a_access(1'b1, 14'd1000, 24'h777777, 3'b111, rd, er, edges, rlow);
    chk("oor_wr_err", {31'd0, er}, 32'd1);
    chk("oor_wr_data", {8'd0, rd}, 32'd0);
    a_access(1'b0, 14'd1000, 24'h0, 3'b000, rd, er, edges, rlow);
    chk("oor_rd_err", {31'd0, er}, 32'd1);
    chk("oor_rd_data", {8'd0, rd}, 32'd0);
    a_access(1'b0, 14'd999, 24'h0, 3'b000, rd, er, edges, rlow);
    chk("rd999_data", {8'd0, rd}, 32'h0A0B0C);
    chk("rd999_err", {31'd0, er}, 32'd0);

    // reset in the middle of a write
    a_access(1'b1, 14'd7, 24'h111111, 3'b111, rd, er, edges, rlow);
    chk("wr7_init", {8'd0, rd}, 32'h111111);
    @(negedge clk);
    ifA.req_valid = 1'b1; ifA.req_write = 1'b1; ifA.req_address = 14'd7;
    ifA.req_write_data = 24'h00AA00; ifA.req_lane_enable = 3'b111;
    @(posedge clk);
    #1;
    ifA.req_valid = 1'b0;
    chk("mid_busy", {31'd0, ifA.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ifA.req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, ifA.resp_valid}, 32'd0);
    chk("mid_rst_data", {8'd0, ifA.resp_read_data}, 32'd0);
    chk("mid_rst_err", {31'd0, ifA.resp_error}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    a_access(1'b0, 14'd7, 24'h0, 3'b000, rd, er, edges, rlow);
    chk("rd7_kept", {8'd0, rd}, 32'h111111);

    // instance B: preload 0..3
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifB.req_valid = 1'b1; ifB.req_write = 1'b1;
      ifB.req_address = 14'(i); ifB.req_write_data = bexp[i];
      ifB.req_lane_enable = 3'b111;
      @(posedge clk);
      #1;
      ifB.req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (ifB.resp_valid) break;
      end
    end

    // zero-wait back-to-back reads, valid held high
    @(negedge clk);
    ifB.req_valid = 1'b1; ifB.req_write = 1'b0; ifB.req_address = '0;
    nacc = 0; nresp = 0; cyc = 0; pulse_bad = 0; prev_v = 0;
    while (nresp < 4 && cyc < 40) begin
      cyc++;
      if (ifB.resp_valid) begin
        if (nresp < 4) chk("b2b_data", {8'd0, ifB.resp_read_data},
                           {8'd0, bexp[nresp]});
        if (prev_v) pulse_bad++;
        nresp++;
      end
      prev_v = ifB.resp_valid;
      if (ifB.req_valid && ifB.req_ready && nacc < 4) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        @(posedge clk);
        #1;
        if (nacc == 4) ifB.req_valid = 1'b0;
        else ifB.req_address = 14'(nacc);
      end
      @(negedge clk);
    end
    ifB.req_valid = 1'b0;
    chk("b2b_nresp", nresp, 32'd4);
    chk("b2b_nacc", nacc, 32'd4);
    chk("b2b_pulse", pulse_bad, 32'd0);
    for (int i = 1; i < 4; i++)
      chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
